ps2_key_gen: RTL and testbench

- Producer end of the 11-bit `ps2_key` event interface that the core top-levels decode: bit 10 toggle, bit 9 pressed, bit 8 extended, bits 7:0 scan code.
- Receives raw PS/2 keyboard clock/data lines and deserialises device-to-host frames.
- Folds the E0/F0 prefixes and the Pause sequence into single key events.
- Drives `ps2_key` with toggle semantics for cores fed from a native PS/2 port rather than the HPS.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_key_gen.sv | 171 +++++++++++++++++
 tb/tb_ps2_key_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard event generator.
//   - frame_state_t : device-to-host frame FSM states
//   - PS2_EXT/PS2_BRK/PS2_PAUSE : prefix bytes folded by the decoder
//   - PAUSE_SKIP    : bytes swallowed after the Pause (E1) lead-in
//   - DISCARD_CODES : keyboard status/ack bytes that never become key events
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int NUM_DISCARD = 6;
    localparam logic [NUM_DISCARD-1:0][7:0] DISCARD_CODES =
        {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    function automatic logic is_discard(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DISCARD; i++) begin
            if (code == DISCARD_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line.
//   Two-flop synchroniser followed by a glitch filter: the filtered level only
//   follows the synchronised input after FILTER_LEN consecutive samples that
//   differ from the current filtered level.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   line_in   : raw asynchronous line
//   filt      : filtered level (resets to 1, the PS/2 idle level)
//   fall      : one-cycle strobe, high in the first cycle filt reads 0
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic filt,
    output logic fall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            fall <= 1'b0;
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                // Run of FILTER_LEN differing samples: commit the new level.
                filt <= sync[1];
                cnt  <= '0;
                fall <= filt;   // only a 1->0 commit is a fall
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_gen.sv
// ps2_key_gen: PS/2 keyboard receiver producing the 11-bit toggle-style
// key event {toggle, pressed, extended, code[7:0]}.
//   Frames are sampled on filtered-clock falls; E0/F0 prefixes are folded into
//   the event and the 8-byte Pause sequence is absorbed.
// Optional build macro: PS2_PARITY_CHECK_EN -- discard bytes with bad odd
//   parity (frame_err pulse); without it the parity bit is ignored.
// Ports:
//   CLK, RESET   : system clock, asynchronous active-high reset
//   ps2_clk_in   : raw PS/2 clock
//   ps2_data_in  : raw PS/2 data
//   ps2_key      : {toggle, pressed, extended, code}
//   key_valid    : one-cycle pulse when ps2_key updates
//   frame_err    : one-cycle pulse when a frame is discarded
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_filt, fall;
    logic data_filt, data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(CLK), .rst(RESET), .line_in(ps2_clk_in),
        .filt(clk_filt), .fall(fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(CLK), .rst(RESET), .line_in(ps2_data_in),
        .filt(data_filt), .fall(data_fall)
    );

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          byte_ok, err;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit, par_bit_n;
`endif

    // Frame FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tmo     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tmo     <= tmo_n;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= par_bit_n;
`endif
        end
    end

    // Frame FSM next state; byte_ok/err are valid in the stop-bit fall cycle
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tmo_n     = tmo;
        byte_ok   = 1'b0;
        err       = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_bit_n = par_bit;
`endif
        if (state != IDLE) tmo_n = tmo + 1'b1;

        if (fall) begin
            // A fall always wins over a simultaneous terminal count.
            tmo_n = '0;
            unique case (state)
                IDLE: begin
                    if (!data_filt) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n   = {data_filt, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_bit_n = data_filt;
`endif
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    if (data_filt && (^{shreg, par_bit})) byte_ok = 1'b1;
                    else                                   err     = 1'b1;
`else
                    if (data_filt) byte_ok = 1'b1;
                    else           err     = 1'b1;
`endif
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tmo == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            tmo_n   = '0;
            err     = 1'b1;
        end
    end

    // Byte decoder and registered outputs
    logic       ext, brk;
    logic [2:0] skip;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ps2_key   <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip      <= '0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= err;
            if (byte_ok) begin
                if (skip != '0) begin
                    skip <= skip - 1'b1;
                end else if (shreg == PS2_PAUSE) begin
                    skip <= PAUSE_SKIP;
                    ext  <= 1'b0;
                    brk  <= 1'b0;
                end else if (shreg == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (shreg == PS2_BRK) begin
                    brk <= 1'b1;
                end else if (is_discard(shreg)) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    ps2_key   <= {~ps2_key[10], ~brk, ext, shreg};
                    key_valid <= 1'b1;
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                end
            end
        end
    end

    // The data line's own fall strobe and clock level are not needed.
    logic unused;
    assign unused = data_fall ^ clk_filt;

endmodule

// File: tb/tb_ps2_key_gen.sv
module tb_ps2_key_gen;

    localparam int TMO = 1000;
    localparam int H   = 20;   // PS/2 half-bit period in CLK cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc  = 1'b1;
    logic        pd  = 1'b1;
    logic [10:0] ps2_key;
    logic        key_valid, frame_err;

    int total = 0;
    int bad   = 0;
    int ev_cnt  = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ps2_key_gen #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .CLK(clk), .RESET(rst), .ps2_clk_in(pc), .ps2_data_in(pd),
        .ps2_key(ps2_key), .key_valid(key_valid), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (key_valid) ev_cnt++;
        if (frame_err) err_cnt++;
    end

    function automatic logic [10:0] mk(input bit t, input bit p, input bit e,
                                       input logic [7:0] c);
        return {t, p, e, c};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; pc = 1'b1; pd = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);
    endtask

    // Sends the first n bits of a frame, LSB first, data changing while clock high.
    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            pd = b[i];
            cyc(H);
            pc = 1'b0;
            cyc(H);
            pc = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad_par = 0,
                             input bit stop = 1);
        send_bits({stop, (~^d) ^ bad_par, d, 1'b0}, 11);
        pd = 1'b1;
        cyc(30);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL reset_key got=%h exp=000", ps2_key); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_make_break();
        int e0;
        do_reset();
        e0 = ev_cnt;
        send_byte(8'h29);
        total++; if (ps2_key !== mk(1, 1, 0, 8'h29)) begin bad++; $display("FAIL make_key got=%h exp=%h", ps2_key, mk(1, 1, 0, 8'h29)); end
        total++; if (ev_cnt - e0 !== 1) begin bad++; $display("FAIL make_events got=%0d exp=1", ev_cnt - e0); end
        send_byte(8'hF0);
        send_byte(8'h29);
        total++; if (ps2_key !== mk(0, 0, 0, 8'h29)) begin bad++; $display("FAIL break_key got=%h exp=%h", ps2_key, mk(0, 0, 0, 8'h29)); end
        total++; if (ev_cnt - e0 !== 2) begin bad++; $display("FAIL break_events got=%0d exp=2", ev_cnt - e0); end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        total++; if (ps2_key !== 11'h775) begin bad++; $display("FAIL ext_make got=%h exp=775", ps2_key); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if (ps2_key !== 11'h175) begin bad++; $display("FAIL ext_break got=%h exp=175", ps2_key); end
    endtask

    task automatic test_discard();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'hFA);   // ack clears the pending extended prefix
        send_byte(8'h29);
        total++; if (ps2_key !== mk(1, 1, 0, 8'h29)) begin bad++; $display("FAIL discard_key got=%h exp=%h", ps2_key, mk(1, 1, 0, 8'h29)); end
    endtask

    task automatic test_pause();
        int e0;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        e0 = ev_cnt;
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        total++; if (ev_cnt - e0 !== 0) begin bad++; $display("FAIL pause_events got=%0d exp=0", ev_cnt - e0); end
        send_byte(8'h05);
        total++; if (ps2_key !== 11'h605) begin bad++; $display("FAIL pause_next got=%h exp=605", ps2_key); end
    endtask

    task automatic test_stop_err();
        int e0, r0;
        do_reset();
        e0 = ev_cnt; r0 = err_cnt;
        send_byte(8'h29, 0, 0);
        total++; if (err_cnt - r0 !== 1) begin bad++; $display("FAIL stop_err got=%0d exp=1", err_cnt - r0); end
        total++; if (ev_cnt - e0 !== 0) begin bad++; $display("FAIL stop_events got=%0d exp=0", ev_cnt - e0); end
        total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL stop_key got=%h exp=000", ps2_key); end
    endtask

    task automatic test_timeout();
        int e0, r0;
        do_reset();
        e0 = ev_cnt; r0 = err_cnt;
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);   // start + 4 data bits
        pd = 1'b1;
        cyc(TMO + 50);
        total++; if (err_cnt - r0 !== 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", err_cnt - r0); end
        total++; if (ev_cnt - e0 !== 0) begin bad++; $display("FAIL tmo_events got=%0d exp=0", ev_cnt - e0); end
        send_byte(8'h1C);
        total++; if (ps2_key !== 11'h61C) begin bad++; $display("FAIL tmo_next got=%h exp=61c", ps2_key); end
        total++; if (err_cnt - r0 !== 1) begin bad++; $display("FAIL tmo_next_err got=%0d exp=1", err_cnt - r0); end
    endtask

    task automatic test_glitch();
        int e0, r0;
        do_reset();
        e0 = ev_cnt; r0 = err_cnt;
        pd = 1'b0;          // a sampled glitch would look like a start bit
        cyc(5);
        pc = 1'b0;
        cyc(2);
        pc = 1'b1;
        cyc(30);
        pd = 1'b1;
        cyc(30);
        send_byte(8'h29);
        total++; if (ps2_key !== mk(1, 1, 0, 8'h29)) begin bad++; $display("FAIL glitch_key got=%h exp=%h", ps2_key, mk(1, 1, 0, 8'h29)); end
        total++; if (ev_cnt - e0 !== 1) begin bad++; $display("FAIL glitch_events got=%0d exp=1", ev_cnt - e0); end
        total++; if (err_cnt - r0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - r0); end
    endtask

    task automatic test_parity();
        int e0, r0;
        do_reset();
        e0 = ev_cnt; r0 = err_cnt;
        send_byte(8'h29, 1, 1);
`ifdef PS2_PARITY_CHECK_EN
        total++; if (err_cnt - r0 !== 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", err_cnt - r0); end
        total++; if (ev_cnt - e0 !== 0) begin bad++; $display("FAIL parity_events got=%0d exp=0", ev_cnt - e0); end
        total++; if (ps2_key !== 11'h000) begin bad++; $display("FAIL parity_key got=%h exp=000", ps2_key); end
`else
        total++; if (err_cnt - r0 !== 0) begin bad++; $display("FAIL parity_err got=%0d exp=0", err_cnt - r0); end
        total++; if (ev_cnt - e0 !== 1) begin bad++; $display("FAIL parity_events got=%0d exp=1", ev_cnt - e0); end
        total++; if (ps2_key !== mk(1, 1, 0, 8'h29)) begin bad++; $display("FAIL parity_key got=%h exp=%h", ps2_key, mk(1, 1, 0, 8'h29)); end
`endif
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_discard();
        test_pause();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
